fifo_sync_flagged: RTL and testbench
====================================

// Module: fifo_sync_flagged
// PURPOSE
//   Parametrised single-clock FIFO. Successor to the basic FIFO: adds programmable
//   almost-full/almost-empty thresholds, fill-level output, sticky overflow/underflow
//   error flags, synchronous flush, and a selectable first-word-fall-through read mode.
//   It sits between a producer and a consumer in the same clock domain as the
//   standard buffering element.
// PARAMETERS
//   DATA_WIDTH    8   width of each data word
//   DEPTH         16  number of entries; power of 2, >= 2
//   AFULL_LEVEL   12  almost_full asserted when level >= AFULL_LEVEL (1..DEPTH)
//   AEMPTY_LEVEL  2   almost_empty asserted when level <= AEMPTY_LEVEL (0..DEPTH-1)
//   FWFT          0   0 = registered read (data 1 cycle after read); 1 = show-ahead
// PORTS
//   clock         in   1                  rising-edge clock
//   reset_n       in   1                  asynchronous, active-low reset
//   flush         in   1                  synchronous empty; drops all stored data
//   err_clear     in   1                  synchronous clear of sticky error flags
//   write_enable  in   1                  write request
//   write_data    in   DATA_WIDTH         write word
//   read_enable   in   1                  read request
//   read_data     out  DATA_WIDTH         read word
//   read_valid    out  1                  read_data is valid (see BEHAVIOUR)
//   fifo_empty    out  1                  level == 0
//   fifo_full     out  1                  level == DEPTH
//   almost_empty  out  1                  level <= AEMPTY_LEVEL
//   almost_full   out  1                  level >= AFULL_LEVEL
//   level         out  $clog2(DEPTH)+1    current number of stored entries
//   overflow      out  1                  sticky: write attempted while full
//   underflow     out  1                  sticky: read attempted while empty
// BEHAVIOUR
// - One clock, one asynchronous active-low reset. While reset_n = 0: pointers = 0,
//   level = 0, read_data = 0, read_valid = 0, overflow = underflow = 0. Outputs then
//   read fifo_empty = 1, almost_empty = 1, fifo_full = 0, and almost_full = 0.
//   Memory contents are not reset.
// - Acceptance uses the pre-edge state: wr_acc = write_enable & !fifo_full, and
//   rd_acc = read_enable & !fifo_empty.
//   A write while full is dropped; a read while empty is ignored.
// - Level update: +1 on wr_acc only, -1 on rd_acc only, unchanged when both are
//   accepted. In particular, both accepted with level == 1 leaves level == 1 and
//   returns the older word.
// - Pointers are $clog2(DEPTH) bits and wrap DEPTH-1 -> 0 naturally.
//   Flags are decoded from level.
// - All flags are combinational from registered level; they update the cycle after
//   the accepting edge.
// - Errors: overflow sets on write_enable & fifo_full; underflow sets on
//   read_enable & fifo_empty. Each stays set until err_clear or reset.
//   If err_clear and a new error occur on the same edge, the flag stays set.
// - flush is synchronous and wins over all reads and writes on that edge.
//   It zeroes the pointers and level and deasserts read_valid.
//   read_data holds its value, and the error flags are unaffected.
// - FWFT = 0: on rd_acc, read_data <= mem[rd_ptr] and read_valid pulses high the
//   next cycle. Otherwise read_valid = 0 and read_data holds its value.
//   Read latency is 1 cycle.
// - FWFT = 1: read_data = mem[rd_ptr] combinationally and read_valid = !fifo_empty.
//   rd_acc pops the head, so the next word appears the following cycle.
//   The first write into an empty FIFO is visible 1 cycle after the write edge.
// - Write/read-same-address hazard cannot occur: a read is only accepted when
//   level >= 1.
// TESTING
// - Reset mid-traffic: drop reset_n asynchronously at level 5 -> level 0,
//   fifo_empty 1, read_valid 0, immediately, without waiting for a clock edge.
// - Fill then drain: write 0x01..0x10 (DEPTH 16) -> fifo_full 1, level 16,
//   almost_full from level 12. Then read 16 times -> data 0x01..0x10 in order,
//   almost_empty from level 2, fifo_empty 1 at the end.
// - Overflow/underflow: write 0xAA while full -> overflow 1, level stays 16,
//   and data is unchanged on drain. Read while empty -> underflow 1.
//   Then err_clear -> both flags 0.
// - Simultaneous read and write: at level 1 (head 0x11), write 0x22 and read on
//   the same edge -> level 1, returns 0x11. The next read returns 0x22.
//   Also check the same at level 16 -> write dropped, read accepted, level 15.
// - Wrap-around: 40 interleaved writes and reads at levels 3..5 -> the output
//   sequence matches the input, with no loss across pointer wrap.
// - Flush and FWFT: with FWFT = 1, write 0x5A to an empty FIFO -> read_data 0x5A
//   and read_valid 1 the next cycle. Then flush with write_enable and read_enable
//   high -> level 0, fifo_empty 1.

Source files
------------

// File: rtl/fifo_sync_flagged.sv
// Single-clock FIFO with programmable almost flags, fill level,
// sticky error flags, synchronous flush and optional show-ahead reads.
module fifo_sync_flagged #(
    parameter int DATA_WIDTH   = 8,
    parameter int DEPTH        = 16,
    parameter int AFULL_LEVEL  = 12,
    parameter int AEMPTY_LEVEL = 2,
    parameter int FWFT         = 0
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       flush,
    input  logic                       err_clear,
    input  logic                       write_enable,
    input  logic [DATA_WIDTH-1:0]      write_data,
    input  logic                       read_enable,
    output logic [DATA_WIDTH-1:0]      read_data,
    output logic                       read_valid,
    output logic                       fifo_empty,
    output logic                       fifo_full,
    output logic                       almost_empty,
    output logic                       almost_full,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic                  wr_acc;
    logic                  rd_acc;

    assign wr_acc = write_enable & ~fifo_full;
    assign rd_acc = read_enable & ~fifo_empty;

    assign fifo_empty   = (level == '0);
    assign fifo_full    = (level == LW'(DEPTH));
    assign almost_empty = (level <= LW'(AEMPTY_LEVEL));
    assign almost_full  = (level >= LW'(AFULL_LEVEL));

    always_ff @(posedge clock) begin
        if (wr_acc && !flush) begin
            mem[wr_ptr] <= write_data;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
            if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
            if (wr_acc && !rd_acc) begin
                level <= level + 1'b1;
            end else if (rd_acc && !wr_acc) begin
                level <= level - 1'b1;
            end
        end
    end

    // A fresh error on the clearing edge takes priority over the clear
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= (overflow & ~err_clear)
                       | (write_enable & fifo_full);
            underflow <= (underflow & ~err_clear)
                       | (read_enable & fifo_empty);
        end
    end

    if (FWFT != 0) begin : g_fwft
        // Head word is shown directly; forced to zero while nothing is stored
        assign read_data  = fifo_empty ? '0 : mem[rd_ptr];
        assign read_valid = ~fifo_empty;
    end else begin : g_reg
        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                read_data  <= '0;
                read_valid <= 1'b0;
            end else if (flush) begin
                read_valid <= 1'b0;
            end else begin
                read_valid <= rd_acc;
                if (rd_acc) read_data <= mem[rd_ptr];
            end
        end
    end

endmodule

// File: tb/tb_fifo_sync_flagged.sv
// Bench for fifo_sync_flagged: registered and show-ahead instances
// driven in parallel and checked against a queue-based model.
module tb_fifo_sync_flagged;

    localparam int DW = 8;
    localparam int DEPTH = 16;
    localparam int AFL = 12;
    localparam int AEL = 2;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          flush = 1'b0;
    logic          err_clear = 1'b0;
    logic          write_enable = 1'b0;
    logic [DW-1:0] write_data = '0;
    logic          read_enable = 1'b0;

    logic [DW-1:0] rd0, rd1;
    logic          rv0, rv1, em0, em1, fu0, fu1;
    logic          ae0, ae1, af0, af1, ov0, ov1, un0, un1;
    logic [4:0]    lv0, lv1;

    int n_cmp = 0;
    int n_bad = 0;

    byte unsigned q[$];
    bit           m_ovf, m_unf, m_rv;
    logic [DW-1:0] m_rd;

    typedef struct {
        bit            we;
        logic [DW-1:0] wd;
        bit            re;
        bit            fl;
        bit            ec;
        int            lvl;
        bit            emp;
        bit            unf;
        bit            rv;
        logic [DW-1:0] rd;
    } vec_t;

    vec_t tbl[9];

    always #5 clock = ~clock;

    fifo_sync_flagged #(
        .DATA_WIDTH(DW), .DEPTH(DEPTH), .AFULL_LEVEL(AFL),
        .AEMPTY_LEVEL(AEL), .FWFT(0)
    ) dut (
        .clock(clock), .reset_n(reset_n), .flush(flush),
        .err_clear(err_clear), .write_enable(write_enable),
        .write_data(write_data), .read_enable(read_enable),
        .read_data(rd0), .read_valid(rv0), .fifo_empty(em0),
        .fifo_full(fu0), .almost_empty(ae0), .almost_full(af0),
        .level(lv0), .overflow(ov0), .underflow(un0)
    );

    fifo_sync_flagged #(
        .DATA_WIDTH(DW), .DEPTH(DEPTH), .AFULL_LEVEL(AFL),
        .AEMPTY_LEVEL(AEL), .FWFT(1)
    ) dut_f (
        .clock(clock), .reset_n(reset_n), .flush(flush),
        .err_clear(err_clear), .write_enable(write_enable),
        .write_data(write_data), .read_enable(read_enable),
        .read_data(rd1), .read_valid(rv1), .fifo_empty(em1),
        .fifo_full(fu1), .almost_empty(ae1), .almost_full(af1),
        .level(lv1), .overflow(ov1), .underflow(un1)
    );

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     nm, got, exp, $time);
        end
    endtask

    task automatic reset_dut();
        reset_n = 1'b0;
        #1;
        chk("rst_level", 32'(lv0), 0);
        chk("rst_empty", 32'(em0), 1);
        chk("rst_aempty", 32'(ae0), 1);
        chk("rst_full", 32'(fu0), 0);
        chk("rst_afull", 32'(af0), 0);
        chk("rst_ovf", 32'(ov0), 0);
        chk("rst_unf", 32'(un0), 0);
        chk("rst_valid", 32'(rv0), 0);
        chk("rst_data", 32'(rd0), 0);
        chk("rst_f_valid", 32'(rv1), 0);
        q.delete();
        m_ovf = 0;
        m_unf = 0;
        m_rv = 0;
        m_rd = '0;
        write_enable = 0;
        read_enable = 0;
        flush = 0;
        err_clear = 0;
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic step(input bit we, input logic [DW-1:0] wd,
                        input bit re, input bit fl, input bit ec);
        bit full, empty;
        int n;
        full = (q.size() == DEPTH);
        empty = (q.size() == 0);
        write_enable = we;
        write_data = wd;
        read_enable = re;
        flush = fl;
        err_clear = ec;
        @(posedge clock);
        #1;
        m_ovf = (m_ovf && !ec) || (we && full);
        m_unf = (m_unf && !ec) || (re && empty);
        m_rv = 0;
        if (fl) begin
            q.delete();
        end else begin
            if (re && !empty) begin
                m_rd = q.pop_front();
                m_rv = 1;
            end
            if (we && !full) q.push_back(wd);
        end
        n = q.size();
        chk("level", 32'(lv0), n);
        chk("empty", 32'(em0), 32'(n == 0));
        chk("full", 32'(fu0), 32'(n == DEPTH));
        chk("aempty", 32'(ae0), 32'(n <= AEL));
        chk("afull", 32'(af0), 32'(n >= AFL));
        chk("ovf", 32'(ov0), 32'(m_ovf));
        chk("unf", 32'(un0), 32'(m_unf));
        chk("valid", 32'(rv0), 32'(m_rv));
        chk("data", 32'(rd0), 32'(m_rd));
        chk("f_level", 32'(lv1), n);
        chk("f_valid", 32'(rv1), 32'(n != 0));
        if (n != 0) chk("f_data", 32'(rd1), 32'(q[0]));
    endtask

    initial begin
        #2ms;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{1, 8'h11, 0, 0, 0, 1, 0, 0, 0, 8'h00};
        tbl[1] = '{1, 8'h22, 1, 0, 0, 1, 0, 0, 1, 8'h11};
        tbl[2] = '{0, 8'h00, 1, 0, 0, 0, 1, 0, 1, 8'h22};
        tbl[3] = '{0, 8'h00, 1, 0, 0, 0, 1, 1, 0, 8'h22};
        tbl[4] = '{0, 8'h00, 0, 0, 1, 0, 1, 0, 0, 8'h22};
        tbl[5] = '{0, 8'h00, 1, 0, 1, 0, 1, 1, 0, 8'h22};
        tbl[6] = '{0, 8'h00, 0, 0, 1, 0, 1, 0, 0, 8'h22};
        tbl[7] = '{1, 8'h33, 0, 0, 0, 1, 0, 0, 0, 8'h22};
        tbl[8] = '{1, 8'h44, 1, 1, 0, 0, 1, 0, 0, 8'h22};

        reset_dut();

        for (int i = 0; i < 9; i++) begin
            step(tbl[i].we, tbl[i].wd, tbl[i].re, tbl[i].fl, tbl[i].ec);
            chk($sformatf("tbl%0d_level", i), 32'(lv0), tbl[i].lvl);
            chk($sformatf("tbl%0d_empty", i), 32'(em0), 32'(tbl[i].emp));
            chk($sformatf("tbl%0d_unf", i), 32'(un0), 32'(tbl[i].unf));
            chk($sformatf("tbl%0d_valid", i), 32'(rv0), 32'(tbl[i].rv));
            chk($sformatf("tbl%0d_data", i), 32'(rd0), 32'(tbl[i].rd));
        end

        // Fill, overflow, drain, underflow, clear
        for (int i = 1; i <= 16; i++) begin
            step(1, 8'(i), 0, 0, 0);
            chk("fill_afull", 32'(af0), 32'(i >= 12));
        end
        chk("fill_full", 32'(fu0), 1);
        chk("fill_level", 32'(lv0), 16);
        step(1, 8'hAA, 0, 0, 0);
        chk("ovf_set", 32'(ov0), 1);
        chk("ovf_level", 32'(lv0), 16);
        for (int i = 1; i <= 16; i++) begin
            step(0, 8'h00, 1, 0, 0);
            chk("drain_data", 32'(rd0), i);
            chk("drain_aempty", 32'(ae0), 32'(16 - i <= 2));
        end
        chk("drain_empty", 32'(em0), 1);
        step(0, 8'h00, 1, 0, 0);
        chk("unf_set", 32'(un0), 1);
        step(0, 8'h00, 0, 0, 1);
        chk("clr_ovf", 32'(ov0), 0);
        chk("clr_unf", 32'(un0), 0);

        // Simultaneous read and write while full
        for (int i = 0; i < 16; i++) step(1, 8'(8'h40 + i), 0, 0, 0);
        step(1, 8'hBB, 1, 0, 0);
        chk("full_rw_level", 32'(lv0), 15);
        chk("full_rw_data", 32'(rd0), 32'h40);
        while (q.size() != 0) step(0, 8'h00, 1, 0, 0);

        // Pointer wrap with level kept between 3 and 5
        for (int i = 0; i < 4; i++) step(1, 8'($urandom), 0, 0, 0);
        for (int i = 0; i < 40; i++) begin
            int l;
            bit we, re;
            l = q.size();
            we = (l == 3) ? 1'b1 : (l == 5) ? 1'b0 : 1'($urandom);
            re = (l == 5) ? 1'b1 : (l == 3) ? 1'b0 : 1'($urandom);
            step(we, 8'($urandom), re, 0, 0);
        end

        // Asynchronous reset in the middle of traffic
        while (q.size() < 6) step(1, 8'($urandom), 0, 0, 0);
        step(0, 8'h00, 1, 0, 0);
        chk("mid_level", 32'(lv0), 5);
        chk("mid_valid", 32'(rv0), 1);
        #1;
        reset_dut();

        // Show-ahead visibility then flush with both requests
        step(1, 8'h5A, 0, 0, 0);
        chk("fwft_data", 32'(rd1), 32'h5A);
        chk("fwft_valid", 32'(rv1), 1);
        step(1, 8'h77, 1, 1, 0);
        chk("flush_level", 32'(lv0), 0);
        chk("flush_empty", 32'(em0), 1);
        chk("flush_f_empty", 32'(em1), 1);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 99) < 55), 8'($urandom),
                 1'($urandom_range(0, 99) < 50),
                 1'($urandom_range(0, 99) < 2),
                 1'($urandom_range(0, 99) < 5));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
